// File: rtl/lcd_ctrl_param.sv
// lcd_ctrl_param: IMG_W x IMG_H image buffer loaded from IROM, edited via a 2x2 window, written to IRAM
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   cmd, cmd_valid        command code and strobe, accepted only while busy=0
//   IROM_rd, IROM_A       ROM read enable and address; IROM_Q is combinational read data
//   IRAM_valid/_A/_D      RAM write enable, address and data
//   busy, done            command-ignore flag, sticky completion flag
module lcd_ctrl_param #(
    parameter int  IMG_W = 8,
    parameter int  IMG_H = 8,
    parameter int  DW    = 8,
    localparam int AW    = $clog2(IMG_W * IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] IROM_Q,
    output logic          IROM_rd,
    output logic [AW-1:0] IROM_A,
    output logic          IRAM_valid,
    output logic [DW-1:0] IRAM_D,
    output logic [AW-1:0] IRAM_A,
    output logic          busy,
    output logic          done
);
    localparam int N  = IMG_W * IMG_H;
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam logic [RW-1:0] ROW_RST = RW'(IMG_H / 2 - 1);
    localparam logic [CW-1:0] COL_RST = CW'(IMG_W / 2 - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 2);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 2);

    typedef enum logic [1:0] {LOAD, CMD, WRITE, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [DW-1:0] pix_q [N];
    logic [DW-1:0] pix_d [N];

    // Widths are powers of two, so the linear address is just {row, col}.
    logic [AW-1:0] a0, a1, a2, a3;
    logic [DW-1:0] p0, p1, p2, p3, n0, n1, n2, n3;
    logic [DW-1:0] mx01, mx23, mx, mn01, mn23, mn;
    logic [DW+1:0] sum;
    logic          wr_win;

    assign a0 = {row_q, col_q};
    assign a1 = {row_q, col_q + CW'(1)};
    assign a2 = {row_q + RW'(1), col_q};
    assign a3 = {row_q + RW'(1), col_q + CW'(1)};
    assign p0 = pix_q[a0];
    assign p1 = pix_q[a1];
    assign p2 = pix_q[a2];
    assign p3 = pix_q[a3];

    assign mx01 = (p0 > p1) ? p0 : p1;
    assign mx23 = (p2 > p3) ? p2 : p3;
    assign mx   = (mx01 > mx23) ? mx01 : mx23;
    assign mn01 = (p0 < p1) ? p0 : p1;
    assign mn23 = (p2 < p3) ? p2 : p3;
    assign mn   = (mn01 < mn23) ? mn01 : mn23;
    assign sum  = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            row_q   <= ROW_RST;
            col_q   <= COL_RST;
            for (int i = 0; i < N; i++) pix_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pix_q   <= pix_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        pix_d   = pix_q;
        n0      = p0;
        n1      = p1;
        n2      = p2;
        n3      = p3;
        wr_win  = 1'b0;
        case (state_q)
            LOAD: begin
                pix_d[cnt_q] = IROM_Q;
                cnt_d        = cnt_q + AW'(1);
                if (cnt_q == AW'(N - 1)) begin
                    state_d = CMD;
                    cnt_d   = '0;
                end
            end
            CMD: begin
                if (cmd_valid) begin
                    case (cmd)
                        4'd0: begin
                            state_d = WRITE;
                            cnt_d   = '0;
                        end
                        4'd1:  row_d = (row_q != '0) ? row_q - RW'(1) : row_q;
                        4'd2:  row_d = (row_q != ROW_MAX) ? row_q + RW'(1) : row_q;
                        4'd3:  col_d = (col_q != '0) ? col_q - CW'(1) : col_q;
                        4'd4:  col_d = (col_q != COL_MAX) ? col_q + CW'(1) : col_q;
                        4'd5:  begin wr_win = 1'b1; {n0, n1, n2, n3} = {4{mx}}; end
                        4'd6:  begin wr_win = 1'b1; {n0, n1, n2, n3} = {4{mn}}; end
                        4'd7:  begin wr_win = 1'b1; {n0, n1, n2, n3} = {4{sum[DW+1:2]}}; end
                        4'd8:  begin wr_win = 1'b1; {n0, n1, n2, n3} = {p1, p3, p0, p2}; end
                        4'd9:  begin wr_win = 1'b1; {n0, n1, n2, n3} = {p2, p0, p3, p1}; end
                        4'd10: begin wr_win = 1'b1; {n0, n1, n2, n3} = {p2, p3, p0, p1}; end
                        4'd11: begin wr_win = 1'b1; {n0, n1, n2, n3} = {p1, p0, p3, p2}; end
                        4'd12: begin wr_win = 1'b1; {n0, n1, n2, n3} = {~p0, ~p1, ~p2, ~p3}; end
                        4'd13: begin row_d = ROW_RST; col_d = COL_RST; end
                        default: ;
                    endcase
                end
            end
            WRITE: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(N - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase
        // The four window addresses are always distinct, so these writes never collide.
        if (wr_win) begin
            pix_d[a0] = n0;
            pix_d[a1] = n1;
            pix_d[a2] = n2;
            pix_d[a3] = n3;
        end
    end

    assign IROM_rd    = (state_q == LOAD);
    assign IROM_A     = (state_q == LOAD) ? cnt_q : '0;
    assign IRAM_valid = (state_q == WRITE);
    assign IRAM_A     = (state_q == WRITE) ? cnt_q : '0;
    assign IRAM_D     = (state_q == WRITE) ? pix_q[cnt_q] : '0;
    assign busy       = (state_q == LOAD) || (state_q == WRITE);
    assign done       = (state_q == DONE);
endmodule
